// File: rtl/dino_pkg.sv
// Shared types and defaults for the dino game input path.
// The jump FSM state encoding and timing defaults live here so other input blocks can reuse them.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } jump_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_HOLD_FRAMES     = 1;
  localparam int DEFAULT_REPEAT_FRAMES   = 4;
  localparam int FRAME_RATE_HZ           = 60;
  localparam int SYNC_STAGES             = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one push-button or switch.
// btn_stable changes only after DEBOUNCE_CYCLES consecutive cycles of disagreement; press_evt marks each 0->1.
module button_debouncer
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic btn_stable,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   stable_reg;
  logic                   evt_reg;
  logic                   btn_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_raw};
    end
  end

  assign btn_sync = sync_reg[SYNC_STAGES-1];

  // Any cycle of agreement restarts the count, so bounces shorter than the window never get through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      evt_reg    <= 1'b0;
    end else begin
      evt_reg <= 1'b0;
      if (btn_sync == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg    <= '0;
        stable_reg <= btn_sync;
        evt_reg    <= btn_sync;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign btn_stable = stable_reg;
  assign press_evt  = evt_reg;

endmodule

// File: rtl/jump_request_conditioner.sv
// Turns debounced jump-button presses into frame-aligned jump requests held for HOLD_FRAMES frames.
// Optional auto-repeat while the button stays held: define JUMP_AUTO_REPEAT_EN.
module jump_request_conditioner
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_FRAMES     = DEFAULT_HOLD_FRAMES,
  parameter int REPEAT_FRAMES   = DEFAULT_REPEAT_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       frame_tick,
  input  logic       inhibit,
  output logic       jump_req,
  output logic       btn_stable,
  output logic [7:0] press_count,
  output logic       busy
);

  // Hold and repeat counters share one width, sized for the larger frame count.
  localparam int FRAME_CNT_W = $clog2(max_int(HOLD_FRAMES, REPEAT_FRAMES) + 1);
  localparam logic [FRAME_CNT_W-1:0] HOLD_LAST = FRAME_CNT_W'(HOLD_FRAMES - 1);

  logic                   press_evt;
  logic                   frame_q_reg;
  logic                   frame_edge;
  jump_state_t            state_reg, state_next;
  logic [FRAME_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0]             press_count_reg, press_count_next;
  logic                   jump_req_reg, busy_reg;
  jump_state_t            exit_state;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .button_raw(button_raw),
    .btn_stable(btn_stable),
    .press_evt (press_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q_reg <= 1'b0;
    end else begin
      frame_q_reg <= frame_tick;
    end
  end

  assign frame_edge = frame_tick & ~frame_q_reg;
  assign exit_state = btn_stable ? WAIT_REL : IDLE;

`ifdef JUMP_AUTO_REPEAT_EN
  localparam logic [FRAME_CNT_W-1:0] REP_LAST = FRAME_CNT_W'(REPEAT_FRAMES - 1);
  logic [FRAME_CNT_W-1:0] rep_cnt_reg, rep_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_reg <= '0;
    end else begin
      rep_cnt_reg <= rep_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      press_count_reg <= '0;
      jump_req_reg    <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      press_count_reg <= press_count_next;
      jump_req_reg    <= (state_next == HOLD);
      busy_reg        <= (state_next == ARMED) || (state_next == HOLD);
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    press_count_next = press_count_reg;
`ifdef JUMP_AUTO_REPEAT_EN
    rep_cnt_next     = rep_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (press_evt && !inhibit) state_next = ARMED;
      end
      ARMED: begin
        if (inhibit) begin
          state_next = IDLE;
        end else if (frame_edge) begin
          state_next       = HOLD;
          hold_cnt_next    = '0;
          press_count_next = press_count_reg + 8'd1;
        end
      end
      HOLD: begin
        if (inhibit || (frame_edge && hold_cnt_reg == HOLD_LAST)) begin
          state_next = exit_state;
`ifdef JUMP_AUTO_REPEAT_EN
          rep_cnt_next = '0;
`endif
        end else if (frame_edge) begin
          hold_cnt_next = hold_cnt_reg + FRAME_CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!btn_stable) begin
          state_next = IDLE;
`ifdef JUMP_AUTO_REPEAT_EN
          rep_cnt_next = '0;
        end else if (inhibit) begin
          rep_cnt_next = '0;
        end else if (frame_edge) begin
          if (rep_cnt_reg == REP_LAST) begin
            state_next   = ARMED;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + FRAME_CNT_W'(1);
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign jump_req    = jump_req_reg;
  assign busy        = busy_reg;
  assign press_count = press_count_reg;

endmodule

// File: tb/tb_jump_request_conditioner.sv
// Directed bench for jump_request_conditioner with DEBOUNCE_CYCLES=4, HOLD_FRAMES=2, REPEAT_FRAMES=4.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_jump_request_conditioner;
  import dino_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_raw = 1'b0;
  logic       frame_tick = 1'b0;
  logic       inhibit = 1'b0;
  logic       jump_req;
  logic       btn_stable;
  logic [7:0] press_count;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_count = 8'd0;

  jump_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_FRAMES    (2),
    .REPEAT_FRAMES  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .frame_tick (frame_tick),
    .inhibit    (inhibit),
    .jump_req   (jump_req),
    .btn_stable (btn_stable),
    .press_count(press_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int gap);
    repeat (gap) tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (jump_req !== 1'b0) begin n_fail++; $display("FAIL reset_jump_req: got %b want 0", jump_req); end
    n_cmp++; if (btn_stable !== 1'b0) begin n_fail++; $display("FAIL reset_btn_stable: got %b want 0", btn_stable); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL reset_press_count: got %0d want 0", press_count); end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    $display("reset: outputs cleared, count=%0d", press_count);
  endtask

  task automatic test_clean_press();
    button_raw = 1'b1;
    repeat (5) tick();
    n_cmp++; if (btn_stable !== 1'b0) begin n_fail++; $display("FAIL clean_stable_early: got %b want 0", btn_stable); end
    tick();
    n_cmp++; if (btn_stable !== 1'b1) begin n_fail++; $display("FAIL clean_stable_at6: got %b want 1", btn_stable); end
    tick();
    n_cmp++; if (busy !== 1'b1 || jump_req !== 1'b0) begin n_fail++; $display("FAIL clean_armed: got busy=%b jr=%b want busy=1 jr=0", busy, jump_req); end
    frame(19);
    exp_count = exp_count + 8'd1;
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL clean_jr_rise: got %b want 1", jump_req); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL clean_count: got %0d want %0d", press_count, exp_count); end
    frame(19);
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL clean_jr_mid: got %b want 1", jump_req); end
    repeat (19) tick();
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL clean_jr_before_exit: got %b want 1", jump_req); end
    frame(0);
    n_cmp++; if (jump_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clean_jr_fall: got jr=%b busy=%b want 0 0", jump_req, busy); end
    button_raw = 1'b0;
    repeat (6) tick();
    n_cmp++; if (btn_stable !== 1'b0) begin n_fail++; $display("FAIL clean_release: got %b want 0", btn_stable); end
    repeat (2) tick();
    $display("clean_press: count=%0d", press_count);
  endtask

  task automatic test_bounce();
    logic seen_stable, seen_jr;
    seen_stable = 1'b0;
    seen_jr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      button_raw = ((i / 2) % 2 == 0);
      tick();
      seen_stable |= btn_stable;
      seen_jr |= jump_req;
    end
    button_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame(1);
      seen_stable |= btn_stable;
      seen_jr |= jump_req;
    end
    n_cmp++; if (seen_stable !== 1'b0) begin n_fail++; $display("FAIL bounce_stable: got %b want 0", seen_stable); end
    n_cmp++; if (seen_jr !== 1'b0) begin n_fail++; $display("FAIL bounce_jr: got %b want 0", seen_jr); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL bounce_count: got %0d want %0d", press_count, exp_count); end
    $display("bounce: no press accepted, count=%0d", press_count);
  endtask

  task automatic test_inhibit_press();
    inhibit = 1'b1;
    button_raw = 1'b1;
    repeat (7) tick();
    frame(5);
    tick();
    n_cmp++; if (btn_stable !== 1'b1) begin n_fail++; $display("FAIL inh_press_stable: got %b want 1", btn_stable); end
    n_cmp++; if (jump_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL inh_press_idle: got jr=%b busy=%b want 0 0", jump_req, busy); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL inh_press_count: got %0d want %0d", press_count, exp_count); end
    button_raw = 1'b0;
    repeat (8) tick();
    inhibit = 1'b0;
    tick();
    $display("inhibit_press: request suppressed, count=%0d", press_count);
  endtask

  task automatic test_inhibit_hold();
    button_raw = 1'b1;
    repeat (7) tick();
    frame(3);
    exp_count = exp_count + 8'd1;
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL inh_hold_jr: got %b want 1", jump_req); end
    inhibit = 1'b1;
    tick();
    n_cmp++; if (jump_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL inh_hold_drop: got jr=%b busy=%b want 0 0", jump_req, busy); end
    n_cmp++; if (dut.state_reg !== WAIT_REL) begin n_fail++; $display("FAIL inh_hold_state: got %0d want %0d", dut.state_reg, WAIT_REL); end
    inhibit = 1'b0;
    button_raw = 1'b0;
    repeat (7) tick();
    n_cmp++; if (dut.state_reg !== IDLE) begin n_fail++; $display("FAIL inh_hold_idle: got %0d want %0d", dut.state_reg, IDLE); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL inh_hold_count: got %0d want %0d", press_count, exp_count); end
    tick();
    $display("inhibit_hold: dropped to WAIT_REL, count=%0d", press_count);
  endtask

  task automatic test_same_cycle_and_level();
    button_raw = 1'b1;
    repeat (6) tick();
    frame_tick = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b1 || jump_req !== 1'b0) begin n_fail++; $display("FAIL same_cycle_armed: got busy=%b jr=%b want 1 0", busy, jump_req); end
    repeat (5) tick();
    n_cmp++; if (jump_req !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL level_single_edge: got jr=%b busy=%b want 0 1", jump_req, busy); end
    frame_tick = 1'b0;
    tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    exp_count = exp_count + 8'd1;
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL same_cycle_next_edge: got %b want 1", jump_req); end
    frame(3);
    frame(3);
    n_cmp++; if (jump_req !== 1'b0) begin n_fail++; $display("FAIL same_cycle_exit: got %b want 0", jump_req); end
    button_raw = 1'b0;
    repeat (8) tick();
    $display("same_cycle_and_level: count=%0d", press_count);
  endtask

  task automatic test_min_latency();
    button_raw = 1'b1;
    repeat (6) tick();
    tick();
    frame_tick = 1'b1;
    n_cmp++; if (jump_req !== 1'b0) begin n_fail++; $display("FAIL minlat_first: got %b want 0", jump_req); end
    tick();
    frame_tick = 1'b0;
    exp_count = exp_count + 8'd1;
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL minlat_second: got %b want 1", jump_req); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL minlat_count: got %0d want %0d", press_count, exp_count); end
    frame(3);
    frame(3);
    button_raw = 1'b0;
    repeat (8) tick();
    $display("min_latency: count=%0d", press_count);
  endtask

  task automatic test_held_frames();
    int windows, exp_windows;
    logic prev;
`ifdef JUMP_AUTO_REPEAT_EN
    exp_windows = 2;
`else
    exp_windows = 1;
`endif
    windows = 0;
    prev = 1'b0;
    button_raw = 1'b1;
    repeat (7) tick();
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < 20; c++) begin
        frame_tick = (c == 19);
        tick();
        if (jump_req && !prev) windows++;
        prev = jump_req;
      end
      frame_tick = 1'b0;
    end
    exp_count = exp_count + 8'(exp_windows);
    n_cmp++; if (windows !== exp_windows) begin n_fail++; $display("FAIL held_windows: got %0d want %0d", windows, exp_windows); end
    n_cmp++; if (press_count !== exp_count) begin n_fail++; $display("FAIL held_count: got %0d want %0d", press_count, exp_count); end
    button_raw = 1'b0;
    repeat (8) tick();
    $display("held_frames: windows=%0d count=%0d", windows, press_count);
  endtask

  task automatic test_reset_mid_hold();
    logic seen_jr;
    button_raw = 1'b1;
    repeat (7) tick();
    frame(3);
    n_cmp++; if (jump_req !== 1'b1) begin n_fail++; $display("FAIL rst_hold_jr_before: got %b want 1", jump_req); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (jump_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_async: got jr=%b busy=%b want 0 0", jump_req, busy); end
    n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL rst_hold_count: got %0d want 0", press_count); end
    exp_count = 8'd0;
    button_raw = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    seen_jr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame(5);
      seen_jr |= jump_req | busy;
    end
    n_cmp++; if (seen_jr !== 1'b0) begin n_fail++; $display("FAIL rst_hold_no_req: got %b want 0", seen_jr); end
    button_raw = 1'b1;
    repeat (7) tick();
    frame(3);
    exp_count = 8'd1;
    n_cmp++; if (jump_req !== 1'b1 || press_count !== exp_count) begin n_fail++; $display("FAIL rst_hold_fresh: got jr=%b count=%0d want 1 %0d", jump_req, press_count, exp_count); end
    frame(3);
    frame(3);
    button_raw = 1'b0;
    repeat (8) tick();
    $display("reset_mid_hold: count=%0d", press_count);
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int n = 1; n <= 256; n++) begin
      button_raw = 1'b1;
      repeat (7) tick();
      frame(1);
      button_raw = 1'b0;
      inhibit = 1'b1;
      tick();
      inhibit = 1'b0;
      repeat (7) tick();
      if (n == 255) begin
        n_cmp++; if (press_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", press_count); end
      end
    end
    n_cmp++; if (press_count !== 8'd0) begin n_fail++; $display("FAIL wrap_256: got %0d want 0", press_count); end
    $display("wrap: 256 presses, count=%0d", press_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_inhibit_press();
    test_inhibit_hold();
    test_same_cycle_and_level();
    test_min_latency();
    test_held_frames();
    test_reset_mid_hold();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
